// File: rtl/beep_pkg.sv
// Shared constants for the status beeper: status codes, FSM states and the
// per-code pattern table (segment count, ON/OFF flag, length in units).
package beep_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_COIN = 2'd1;
  localparam logic [1:0] ST_VEND = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } state_e;

  // Number of segments in the pattern for a code.
  function automatic logic [1:0] seg_num(input logic [1:0] code);
    logic [1:0] n;
    case (code)
      ST_VEND: n = 2'd3;
      default: n = 2'd1;
    endcase
    return n;
  endfunction

  // 1 = sounding segment, 0 = silent gap.
  function automatic logic seg_on(input logic [1:0] code, input logic [1:0] idx);
    logic on;
    case (code)
      ST_VEND: on = (idx != 2'd1);
      default: on = 1'b1;
    endcase
    return on;
  endfunction

  // Segment length in units; every segment of a pattern has the same length.
  function automatic logic [2:0] seg_units(input logic [1:0] code);
    logic [2:0] u;
    case (code)
      ST_ERR:  u = 3'd4;
      default: u = 3'd1;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/tone_div.sv
// Toggle divider for the buzzer tone: clear loads phase 0 with sq high,
// en advances the phase and flips sq every HALF cycles.
module tone_div #(
  parameter int unsigned HALF = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic sq
);

  localparam int unsigned HW = (HALF > 1) ? $clog2(HALF) : 1;

  logic [HW-1:0] cnt_q, cnt_d;
  logic          sq_q, sq_d;

  always_comb begin
    cnt_d = cnt_q;
    sq_d  = sq_q;
    if (clear) begin
      cnt_d = '0;
      sq_d  = 1'b1;
    end else if (en) begin
      if (cnt_q == HW'(HALF - 1)) begin
        cnt_d = '0;
        sq_d  = ~sq_q;
      end else begin
        cnt_d = cnt_q + HW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      sq_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sq_q  <= sq_d;
    end
  end

  assign sq = sq_q;

endmodule

// File: rtl/status_beep_seq.sv
// Turns vending status events into timed buzzer patterns (coin/vend/error).
// Optional BEEP_MUTE_EN adds a mute input that silences beep only.
module status_beep_seq
  import beep_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned TONE_HZ = 2_000,
  parameter int unsigned UNIT_MS = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] status,
`ifdef BEEP_MUTE_EN
  input  logic       mute,
`endif
  output logic       beep,
  output logic       busy
);

  localparam int unsigned HALF_RAW = CLK_HZ / (2 * TONE_HZ);
  localparam int unsigned HALF     = (HALF_RAW < 1) ? 1 : HALF_RAW;
  localparam int unsigned UNIT_RAW = CLK_HZ / 1000 * UNIT_MS;
  localparam int unsigned UNIT     = (UNIT_RAW < 1) ? 1 : UNIT_RAW;
  localparam int unsigned CNT_W    = $clog2(4 * UNIT);

  state_e           state_q, state_d;
  logic [1:0]       status_q;
  logic [1:0]       code_q, code_d;
  logic [1:0]       seg_idx_q, seg_idx_d;
  logic [CNT_W-1:0] seg_cnt_q, seg_cnt_d;
  logic [CNT_W-1:0] seg_last;
  logic [1:0]       next_idx;
  int unsigned      units;
  logic             trig, restart, tone_clear, tone_en, tone_sq;

  always_comb begin
    units    = 32'(seg_units(code_q));
    seg_last = CNT_W'(units * UNIT - 1);
    next_idx = seg_idx_q + 2'd1;
    trig     = (status != status_q) && (status != ST_IDLE);
    // Equal-or-higher priority restarts; the code value doubles as priority.
    restart  = trig && ((state_q == IDLE) || (status >= code_q));
  end

  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    seg_idx_d  = seg_idx_q;
    seg_cnt_d  = seg_cnt_q;
    tone_clear = 1'b0;
    if (restart) begin
      state_d    = ON;
      code_d     = status;
      seg_idx_d  = '0;
      seg_cnt_d  = '0;
      tone_clear = 1'b1;
    end else begin
      unique case (state_q)
        ON, GAP: begin
          if (seg_cnt_q == seg_last) begin
            seg_cnt_d = '0;
            if (seg_idx_q == seg_num(code_q) - 2'd1) begin
              state_d   = IDLE;
              seg_idx_d = '0;
            end else begin
              seg_idx_d = next_idx;
              if (seg_on(code_q, next_idx)) begin
                state_d    = ON;
                tone_clear = 1'b1;
              end else begin
                state_d = GAP;
              end
            end
          end else begin
            seg_cnt_d = seg_cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      status_q  <= ST_IDLE;
      code_q    <= ST_IDLE;
      seg_idx_q <= '0;
      seg_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      status_q  <= status;
      code_q    <= code_d;
      seg_idx_q <= seg_idx_d;
      seg_cnt_q <= seg_cnt_d;
    end
  end

  assign tone_en = (state_q == ON);

  tone_div #(
    .HALF(HALF)
  ) u_tone_div (
    .clk  (clk),
    .rst  (rst),
    .clear(tone_clear),
    .en   (tone_en),
    .sq   (tone_sq)
  );

  assign busy = (state_q != IDLE);
`ifdef BEEP_MUTE_EN
  assign beep = tone_sq & (state_q == ON) & ~mute;
`else
  assign beep = tone_sq & (state_q == ON);
`endif

endmodule
